// File: rtl/hpu_pkg.sv
// hpu_pkg: shared types for the HPU load/store path.
// Holds the memory request/response structs exchanged with the memory
// router and the LSU enums: access size, fault cause and sequencer state.
package hpu_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] pc_t;
  typedef logic [3:0]  data_strobe_t;

  typedef struct packed {
    logic         wr_en;
    pc_t          waddr;
    data_t        wdata;
    data_strobe_t wstrb;
    logic         rl_lock;
  } mem_wr_req_t;

  typedef struct packed {
    logic wr_suc;
  } mem_wr_rsp_t;

  typedef struct packed {
    logic rd_en;
    pc_t  raddr;
    logic aq_lock;
  } mem_rd_req_t;

  typedef struct packed {
    logic  rd_suc;
    data_t rdata;
  } mem_rd_rsp_t;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    LSU_EXC_LD_MISALIGN = 2'd0,
    LSU_EXC_ST_MISALIGN = 2'd1,
    LSU_EXC_LD_ACCESS   = 2'd2,
    LSU_EXC_ST_ACCESS   = 2'd3
  } lsu_exc_e;

  typedef enum logic [2:0] {
    LSU_S_IDLE,
    LSU_S_ISSUE,
    LSU_S_WAIT_SUC,
    LSU_S_WAIT_DATA,
    LSU_S_RESP
  } lsu_state_e;

  localparam int LSU_RETRY_MAX = 15;

  // Size code 3 is illegal and is reported as a misalignment.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'd3) ||
           ((size == LSU_HALF) && off[0]) ||
           ((size == LSU_WORD) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/hpu_lsu_align.sv
// hpu_lsu_align: combinational data alignment for the LSU.
// Ports:
//   size_i, off_i   access size code and byte offset addr[1:0]
//   sext_i          sign-extend load data
//   st_data_i       right-justified store data
//   ld_raw_i        raw 32-bit word returned by memory
//   wstrb_o         byte strobes for the store
//   wdata_o         store data replicated across all byte lanes
//   ld_data_o       load data shifted down, masked and extended
module hpu_lsu_align
  import hpu_pkg::*;
(
  input  logic [1:0]   size_i,
  input  logic [1:0]   off_i,
  input  logic         sext_i,
  input  data_t        st_data_i,
  input  data_t        ld_raw_i,
  output data_strobe_t wstrb_o,
  output data_t        wdata_o,
  output data_t        ld_data_o
);

  data_t ld_shift;

  // Replicating store data means memory can pick any lane by strobe alone.
  always_comb begin
    wstrb_o = 4'hF;
    wdata_o = st_data_i;
    case (size_i)
      LSU_BYTE: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      LSU_HALF: begin
        wstrb_o = 4'b0011 << off_i;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        wstrb_o = 4'hF;
        wdata_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    ld_shift  = ld_raw_i >> {off_i, 3'b000};
    ld_data_o = ld_shift;
    case (size_i)
      LSU_BYTE: ld_data_o = {{24{sext_i & ld_shift[7]}}, ld_shift[7:0]};
      LSU_HALF: ld_data_o = {{16{sext_i & ld_shift[15]}}, ld_shift[15:0]};
      default:  ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/hpu_lsu_mem_ctrl.sv
// hpu_lsu_mem_ctrl: single-outstanding load/store sequencer feeding the
// memory router. Accepts one op in IDLE, issues a read or write request,
// retries on suc=0 up to RETRY_MAX times, then returns a registered
// writeback, store-done or fault pulse.
// Ports:
//   op_*_i / op_rdy_o     op handshake: an op transfers on a cycle where
//                         op_vld_i and op_rdy_o are both high; op_rdy_o
//                         does not depend on op_vld_i.
//   flush_i               abandons loads in flight; stores always complete
//   lsu_mem__*_req_o      request, driven only in the ISSUE cycle
//   mem_lsu__*_rsp_i      success flag (cycle after ISSUE), read data (after that)
//   wb_*_o, st_done_o     completion pulses
//   exc_*_o               fault pulse, cause and faulting address
module hpu_lsu_mem_ctrl
  import hpu_pkg::*;
#(
  parameter int RETRY_MAX = LSU_RETRY_MAX,
  parameter int RETRY_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_vld_i,
  output logic        op_rdy_o,
  input  logic        op_is_st_i,
  input  logic [1:0]  op_size_i,
  input  logic        op_sext_i,
  input  logic        op_lr_i,
  input  logic        op_sc_i,
  input  pc_t         op_addr_i,
  input  data_t       op_wdata_i,
  input  logic [4:0]  op_rd_i,
  input  logic        flush_i,
  output mem_wr_req_t lsu_mem__wr_req_o,
  input  mem_wr_rsp_t mem_lsu__wr_rsp_i,
  output mem_rd_req_t lsu_mem__rd_req_o,
  input  mem_rd_rsp_t mem_lsu__rd_rsp_i,
  output logic        wb_vld_o,
  output logic [4:0]  wb_rd_o,
  output data_t       wb_data_o,
  output logic        st_done_o,
  output logic        exc_vld_o,
  output logic [1:0]  exc_cause_o,
  output pc_t         exc_addr_o
);

  lsu_state_e         state_q, state_d;
  logic               alive_q, alive_d;
  logic               is_st_q, is_st_d;
  logic [1:0]         size_q, size_d;
  logic               sext_q, sext_d;
  logic               lr_q, lr_d;
  logic               sc_q, sc_d;
  pc_t                addr_q, addr_d;
  data_t              wdata_q, wdata_d;
  logic [4:0]         rd_q, rd_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               wb_vld_q, wb_vld_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  data_t              wb_data_q, wb_data_d;
  logic               st_done_q, st_done_d;
  logic               exc_vld_q, exc_vld_d;
  logic [1:0]         exc_cause_q, exc_cause_d;
  pc_t                exc_addr_q, exc_addr_d;

  data_strobe_t al_wstrb;
  data_t        al_wdata;
  data_t        al_ld_data;
  logic         accept;
  logic         ld_flush;
  logic         suc;

  hpu_lsu_align u_align (
    .size_i    (size_q),
    .off_i     (addr_q[1:0]),
    .sext_i    (sext_q),
    .st_data_i (wdata_q),
    .ld_raw_i  (mem_lsu__rd_rsp_i.rdata),
    .wstrb_o   (al_wstrb),
    .wdata_o   (al_wdata),
    .ld_data_o (al_ld_data)
  );

  // alive_q keeps ready low until the first clock edge after reset release.
  assign op_rdy_o = alive_q && (state_q == LSU_S_IDLE) && !flush_i;
  assign accept   = op_rdy_o && op_vld_i;
  assign ld_flush = flush_i && !is_st_q;
  assign suc      = is_st_q ? mem_lsu__wr_rsp_i.wr_suc : mem_lsu__rd_rsp_i.rd_suc;

  // Requests are zero outside ISSUE so reset clears them asynchronously.
  always_comb begin
    lsu_mem__wr_req_o = '0;
    lsu_mem__rd_req_o = '0;
    if (state_q == LSU_S_ISSUE) begin
      if (is_st_q) begin
        lsu_mem__wr_req_o.wr_en   = 1'b1;
        lsu_mem__wr_req_o.waddr   = addr_q;
        lsu_mem__wr_req_o.wdata   = al_wdata;
        lsu_mem__wr_req_o.wstrb   = al_wstrb;
        lsu_mem__wr_req_o.rl_lock = sc_q;
      end else begin
        lsu_mem__rd_req_o.rd_en   = 1'b1;
        lsu_mem__rd_req_o.raddr   = addr_q;
        lsu_mem__rd_req_o.aq_lock = lr_q;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    alive_d     = 1'b1;
    is_st_d     = is_st_q;
    size_d      = size_q;
    sext_d      = sext_q;
    lr_d        = lr_q;
    sc_d        = sc_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    retry_d     = retry_q;
    wb_vld_d    = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    st_done_d   = 1'b0;
    exc_vld_d   = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;
    case (state_q)
      LSU_S_IDLE: begin
        if (accept) begin
          is_st_d = op_is_st_i;
          size_d  = op_size_i;
          sext_d  = op_sext_i;
          lr_d    = op_lr_i;
          sc_d    = op_sc_i;
          addr_d  = op_addr_i;
          wdata_d = op_wdata_i;
          rd_d    = op_rd_i;
          retry_d = '0;
          if (lsu_misaligned(op_size_i, op_addr_i[1:0])) begin
            exc_vld_d   = 1'b1;
            exc_cause_d = op_is_st_i ? LSU_EXC_ST_MISALIGN : LSU_EXC_LD_MISALIGN;
            exc_addr_d  = op_addr_i;
          end else begin
            state_d = LSU_S_ISSUE;
          end
        end
      end
      LSU_S_ISSUE: begin
        state_d = ld_flush ? LSU_S_IDLE : LSU_S_WAIT_SUC;
      end
      LSU_S_WAIT_SUC: begin
        if (ld_flush) begin
          state_d = LSU_S_IDLE;
        end else if (!suc) begin
          if (retry_q < RETRY_W'(RETRY_MAX)) begin
            retry_d = retry_q + 1'b1;
            state_d = LSU_S_ISSUE;
          end else begin
            exc_vld_d   = 1'b1;
            exc_cause_d = is_st_q ? LSU_EXC_ST_ACCESS : LSU_EXC_LD_ACCESS;
            exc_addr_d  = addr_q;
            state_d     = LSU_S_RESP;
          end
        end else if (is_st_q) begin
          st_done_d = 1'b1;
          state_d   = LSU_S_RESP;
        end else begin
          state_d = LSU_S_WAIT_DATA;
        end
      end
      LSU_S_WAIT_DATA: begin
        if (ld_flush) begin
          state_d = LSU_S_IDLE;
        end else begin
          wb_vld_d  = 1'b1;
          wb_rd_d   = rd_q;
          wb_data_d = al_ld_data;
          state_d   = LSU_S_RESP;
        end
      end
      LSU_S_RESP: state_d = LSU_S_IDLE;
      default:    state_d = LSU_S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= LSU_S_IDLE;
      alive_q     <= 1'b0;
      is_st_q     <= 1'b0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      lr_q        <= 1'b0;
      sc_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      retry_q     <= '0;
      wb_vld_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      st_done_q   <= 1'b0;
      exc_vld_q   <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      alive_q     <= alive_d;
      is_st_q     <= is_st_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      lr_q        <= lr_d;
      sc_q        <= sc_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      retry_q     <= retry_d;
      wb_vld_q    <= wb_vld_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      st_done_q   <= st_done_d;
      exc_vld_q   <= exc_vld_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign wb_vld_o    = wb_vld_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign st_done_o   = st_done_q;
  assign exc_vld_o   = exc_vld_q;
  assign exc_cause_o = exc_cause_q;
  assign exc_addr_o  = exc_addr_q;

endmodule
